// File: rtl/boolean_pkg.sv
// Shared types and helpers for the operand-collect datapath.
package boolean_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/p_collect_if.sv
// Operand-in / result-out handshake bundle for p_collect.
interface p_collect_if
    import boolean_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NB_INS    = 4,
    parameter int CNT_W     = cnt_w(NB_INS)
);
    logic [BUS_WIDTH-1:0] in_bus;
    logic                 in_valid;
    logic                 in_ready;
    logic                 clear;
    logic [BUS_WIDTH-1:0] out_bus;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_W-1:0]     count;

    modport master (
        output in_bus, in_valid, clear, out_ready,
        input  in_ready, out_bus, out_valid, count
    );

    modport slave (
        input  in_bus, in_valid, clear, out_ready,
        output in_ready, out_bus, out_valid, count
    );
endinterface

// File: rtl/p_and.sv
// Bitwise AND reduction across all operand slots.
module p_and #(
    parameter int BUS_WIDTH = 8,
    parameter int NB_INS    = 4
) (
    input  logic [NB_INS-1:0][BUS_WIDTH-1:0] op_i,
    output logic [BUS_WIDTH-1:0]             res_o
);
    always_comb begin
        res_o = '1;
        for (int i = 0; i < NB_INS; i++) begin
            res_o = res_o & op_i[i];
        end
    end
endmodule

// File: rtl/p_collect.sv
// Collects NB_INS operand beats, then presents their AND until consumed.
module p_collect
    import boolean_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NB_INS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    p_collect_if.slave  bus
);
    localparam int CNT_W = cnt_w(NB_INS);
    localparam int IDX_W = (NB_INS > 1) ? $clog2(NB_INS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_INS - 1);

    state_e                          state_q;
    logic [CNT_W-1:0]                count_q;
    logic [NB_INS-1:0][BUS_WIDTH-1:0] slot_q;
    logic [IDX_W-1:0]                idx;

    assign idx = IDX_W'(count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            count_q <= '0;
            slot_q  <= '0;
        end else if (bus.clear) begin
            state_q <= COLLECT;
            count_q <= '0;
            slot_q  <= '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (bus.in_valid) begin
                        slot_q[idx] <= bus.in_bus;
                        count_q     <= count_q + 1'b1;
                        if (count_q == LAST) begin
                            state_q <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        state_q <= COLLECT;
                        count_q <= '0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == COLLECT) && !bus.clear;
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.count     = count_q;

    p_and #(
        .BUS_WIDTH (BUS_WIDTH),
        .NB_INS    (NB_INS)
    ) u_and (
        .op_i  (slot_q),
        .res_o (bus.out_bus)
    );
endmodule

// File: tb/tb_p_collect.sv
// Directed, table-driven checks of p_collect with BUS_WIDTH=8, NB_INS=4.
module tb_p_collect;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    p_collect_if #(.BUS_WIDTH(8), .NB_INS(4)) bus ();

    p_collect #(.BUS_WIDTH(8), .NB_INS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_cnt;
        logic       chk_bus;
        logic [7:0] e_bus;
        string      name;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic clr, input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_bus    = d;
        bus.clear     = clr;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic add(input string nm, input logic v, input logic [7:0] d,
                       input logic clr, input logic ordy, input logic e_ir,
                       input logic e_ov, input logic [2:0] e_cnt,
                       input logic chk_bus, input logic [7:0] e_bus);
        vec_t t;
        t.name = nm; t.v = v; t.d = d; t.clr = clr; t.ordy = ordy;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_cnt = e_cnt;
        t.chk_bus = chk_bus; t.e_bus = e_bus;
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] beats [4];
        int         model;

        beats[0] = 8'hFF; beats[1] = 8'hF0;
        beats[2] = 8'h3C; beats[3] = 8'hAA;

        // back-to-back with consumer always ready
        for (int i = 0; i < 4; i++)
            add($sformatf("bb_beat%0d", i), 1, beats[i], 0, 1, 1, 0, 3'(i), 0, 0);
        add("bb_present", 0, 8'h00, 0, 1, 0, 1, 4, 1, 8'h20);
        add("bb_after",   0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        // consumer stalls for 5 cycles while in_valid toggles
        for (int i = 0; i < 4; i++)
            add($sformatf("st_beat%0d", i), 1, beats[i], 0, 0, 1, 0, 3'(i), 0, 0);
        for (int i = 0; i < 5; i++)
            add($sformatf("st_hold%0d", i), 1'(~i[0]), 8'h00, 0, 0, 0, 1, 4, 1, 8'h20);
        add("st_take",  0, 8'h00, 0, 1, 0, 1, 4, 1, 8'h20);
        add("st_after", 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        // partial collection, clear, then fresh collection
        add("cl_b0",  1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        add("cl_b1",  1, 8'h00, 0, 0, 1, 0, 1, 0, 0);
        add("cl_clr", 0, 8'h00, 1, 0, 0, 0, 2, 0, 0);
        add("cl_n0",  1, 8'h0F, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++)
            add($sformatf("cl_n%0d", i), 1, 8'hFF, 0, 0, 1, 0, 3'(i), 0, 0);
        add("cl_present", 0, 8'h00, 0, 1, 0, 1, 4, 1, 8'h0F);
        add("cl_after",   0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        // clear coincident with a valid beat
        add("cv_b0",   1, 8'h0F, 0, 0, 1, 0, 0, 0, 0);
        add("cv_clr",  1, 8'h00, 1, 0, 0, 0, 1, 0, 0);
        add("cv_zero", 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add($sformatf("cv_n%0d", i), 1, 8'hFF, 0, 0, 1, 0, 3'(i), 0, 0);
        add("cv_present", 0, 8'h00, 0, 1, 0, 1, 4, 1, 8'hFF);
        add("cv_after",   0, 8'h00, 0, 0, 1, 0, 0, 0, 0);

        bus.in_valid = 0; bus.in_bus = 0; bus.clear = 0; bus.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_ir",    32'(bus.in_ready),  1);
        check("rst_ov",    32'(bus.out_valid), 0);
        check("rst_cnt",   32'(bus.count),     0);
        check("rst_bus",   32'(bus.out_bus),   0);

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].d, tbl[k].clr, tbl[k].ordy);
            check({tbl[k].name, "_ir"},  32'(bus.in_ready),  32'(tbl[k].e_ir));
            check({tbl[k].name, "_ov"},  32'(bus.out_valid), 32'(tbl[k].e_ov));
            check({tbl[k].name, "_cnt"}, 32'(bus.count),     32'(tbl[k].e_cnt));
            if (tbl[k].chk_bus)
                check({tbl[k].name, "_bus"}, 32'(bus.out_bus), 32'(tbl[k].e_bus));
        end

        // random idle gaps between beats
        model = 0;
        for (int i = 0; i < 4; i++) begin
            int gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                drive(0, 8'h00, 0, 0);
                check($sformatf("gap%0d_idle%0d_cnt", i, g), 32'(bus.count), 32'(model));
            end
            drive(1, beats[i], 0, 0);
            check($sformatf("gap%0d_beat_cnt", i), 32'(bus.count), 32'(model));
            model++;
        end
        drive(0, 8'h00, 0, 1);
        check("gap_ov",  32'(bus.out_valid), 1);
        check("gap_cnt", 32'(bus.count),     4);
        check("gap_bus", 32'(bus.out_bus),   32'h20);
        drive(0, 8'h00, 0, 0);
        check("gap_after_cnt", 32'(bus.count), 0);

        // reset while holding a result
        for (int i = 0; i < 4; i++) drive(1, 8'hFF, 0, 0);
        drive(0, 8'h00, 0, 0);
        check("pr_ov", 32'(bus.out_valid), 1);
        check("pr_bus", 32'(bus.out_bus), 32'hFF);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("pr_rst_ov",  32'(bus.out_valid), 0);
        check("pr_rst_bus", 32'(bus.out_bus),   0);
        check("pr_rst_cnt", 32'(bus.count),     0);
        check("pr_rst_ir",  32'(bus.in_ready),  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/p_collect.md
P_COLLECT -- requirements
Module: p_collect

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, giving the width of each operand bus in bits.
REQ-002 The block SHALL have parameter NB_INS, default 4, giving the number of operands collected per result; legal range 1..64.
REQ-003 The block SHALL use one clock and one reset: clk input 1 (sole clock, rising edge) and rst input 1 (reset, synchronous, active-high).
REQ-004 The block SHALL have port in_bus, input, BUS_WIDTH bits: the operand beat.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_bus holds a valid beat.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous abort of the current collection.
REQ-008 The block SHALL have port out_bus, output, BUS_WIDTH bits: bitwise AND of all collected operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_bus holds a complete result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port count, output, CNT_W = clog2(NB_INS)+1 bits: number of operands held.

Function
REQ-012 The block SHALL have two FSM states: COLLECT (gathering operands) and PRESENT (holding a result).
REQ-013 A beat SHALL be accepted exactly when in_valid & in_ready is high at a rising edge.
REQ-014 in_ready SHALL be high only in COLLECT with clear low; it SHALL be combinational from state and clear only, never from in_valid.
REQ-015 Each accepted beat SHALL be stored in operand slot[count], and count SHALL then increment by 1.
REQ-016 The beat that brings count to NB_INS SHALL move the FSM to PRESENT, with out_valid high on the next cycle (1-cycle latency).
REQ-017 With NB_INS=1, every accepted beat SHALL go straight to PRESENT.
REQ-018 out_valid SHALL be high in PRESENT and low in COLLECT.
REQ-019 While out_valid is high and out_ready is low, out_bus and count SHALL hold stable and in_valid SHALL be ignored.
REQ-020 When out_valid & out_ready are high at an edge, the FSM SHALL return to COLLECT with count=0; in_ready SHALL rise the following cycle (no same-cycle bypass).
REQ-021 out_bus SHALL be the combinational AND of all NB_INS slot registers and is defined only while out_valid is high.
REQ-022 When clear is high at an edge, count SHALL go to 0, all slots SHALL go to 0, the FSM SHALL go to COLLECT, and any concurrent beat or result handshake SHALL be discarded.
REQ-023 Priority SHALL be rst > clear > handshakes.
REQ-024 count SHALL never exceed NB_INS and SHALL not wrap.

Reset
REQ-025 On rst high at an edge, the block SHALL enter COLLECT with count=0 and all slots 0, so out_valid=0 and out_bus=0.
REQ-026 After reset, in_ready SHALL be 1 on the first cycle with rst low and clear low.
REQ-027 Reset asserted mid-collection or in PRESENT SHALL drop all partial data and any pending result without emitting it.

Structure
REQ-028 The state enum (COLLECT, PRESENT) SHALL live in shared package boolean_pkg, together with a clog2-based CNT_W helper function.
REQ-029 The AND reduction SHALL be a single instance of sub-module p_and (BUS_WIDTH, NB_INS) fed by the slot array; it SHALL not be reimplemented inline.
REQ-030 Slots SHALL be a BUS_WIDTH x NB_INS register array written only at index count.

Verification
REQ-031 Bench SHALL drive back-to-back beats FF,F0,3C,AA with out_ready=1 (BUS_WIDTH=8, NB_INS=4) and check: out_valid=1 the cycle after the 4th accept, out_bus=0x20, in_ready=0 that cycle, then count=0 and in_ready=1 one cycle later.
REQ-032 Bench SHALL hold out_ready=0 for 5 cycles in PRESENT while toggling in_valid and check: out_bus stays 0x20, out_valid stays 1, in_ready stays 0, count stays 4.
REQ-033 Bench SHALL insert idle gaps of 0-3 cycles between beats and check that count rises only on accepts and the result is still 0x20.
REQ-034 Bench SHALL send beats 00,00, then clear, then 0F,FF,FF,FF and check out_bus=0x0F (no leftover data).
REQ-035 Bench SHALL assert clear with in_valid=1 in the same cycle and check the beat is dropped, in_ready=0 that cycle, and count=0.
REQ-036 Bench SHALL assert rst for one cycle in PRESENT and check the next cycle gives out_valid=0, out_bus=0x00, count=0, in_ready=1.
